booth_radix4_mul: RTL and testbench
===================================

Name: booth_radix4_mul

Overview:
Parametrised radix-4 (modified) Booth multiplier. It is the next generation of the team's 8-bit radix-2 Booth datapath. Width is generic, it supports a signed/unsigned mode, it retires two multiplier bits per cycle, and it uses valid/ready handshakes on both sides. It sits between an operand-issue stage and a result consumer; the product is presented in parallel and held until accepted.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands presented
in_ready  out  1  block can accept operands
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
multiplicand  in  WIDTH  operand M
multiplier  in  WIDTH  operand Q
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  M*Q, signed or unsigned per latched mode
busy  out  1  high in CALC

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset, asserted at any time including mid-operation:
  - state = IDLE; all internal registers cleared.
  - in_ready=1, out_valid=0, busy=0, product=0.
  - No partial result ever surfaces.
- Internal extended width EW = WIDTH+2.
  - Operands are sign-extended when signed_mode=1, zero-extended otherwise.
  - This makes unsigned and signed share one datapath.
- Iteration count N = EW/2 = WIDTH/2+1 (5 for WIDTH=8).
- Registers:
  - accumulator A, WIDTH+4 bits (EW+2), so A ± 2M never overflows;
  - Q, EW bits; Qm, 1 bit; latched M, EW bits;
  - iteration counter, clog2(N+1) bits.
- FSM IDLE -> CALC -> DONE -> IDLE:
  - IDLE: in_ready=1. When in_valid & in_ready at an edge: load M and Q (extended), A=0, Qm=0, count=0, latch signed_mode; go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle:
    - recode {Q[1],Q[0],Qm}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
    - A' = A + pp, where negation is two's complement and 2M is M shifted left 1 with sign-extension.
    - Arithmetic shift of {A',Q,Qm} right by 2; count++.
    - When count reaches N-1 on this cycle's update, go to DONE.
  - DONE: out_valid=1, busy=0. product = low 2*WIDTH bits of {A,Q}, registered on entry and stable while out_valid=1. When out_ready=1 at an edge: out_valid drops and the FSM goes to IDLE.
- Latency: accept on edge k; out_valid high after edge k+N. Throughput is one product per N+2 cycles with out_ready tied high.
- in_ready=0 in CALC and DONE. in_valid there is ignored and not queued; the producer must hold its operands.
- Operand inputs are sampled only at the accepting edge. Later changes do not affect the result.
- Backpressure: out_ready low holds DONE indefinitely, and product does not change.
- product holds the last result in IDLE until the next DONE entry.
- Corner results are exact with no overflow, e.g. most-negative × most-negative in signed mode, and all-ones × all-ones in unsigned mode.

Decomposition:
- Package booth_pkg holds:
  - state_e {IDLE, CALC, DONE};
  - booth_op_e {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M};
  - function booth_recode(logic [2:0]) returning booth_op_e.
- One natural sub-module: booth_pp_gen. It is combinational: op plus M in, EW+2-bit partial product out.
- FSM, counter and shift registers stay in the top module.

Test Plan:
1. WIDTH=8, signed_mode=1, M=8'hFD (-3), Q=8'h07 -> out_valid exactly 5 cycles after the accept edge, product=16'hFFEB (-21).
2. WIDTH=8, signed_mode=1, M=Q=8'h80 -> product=16'h4000. Same operands with signed_mode=0 -> 16'h4000; M=Q=8'hFF unsigned -> 16'hFE01, signed -> 16'h0001.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with new operands -> product stable, in_ready=0, new operands not accepted. Raise out_ready -> out_valid drops next edge, then in_ready=1.
4. Assert rst asynchronously mid-edge in the 2nd CALC cycle -> out_valid=0, product=0, busy=0, in_ready=1 immediately. After release, 8'h05*8'h06 signed -> 16'h001E.
5. Operands changed on the cycle after acceptance (M=8'h03,Q=8'h04, then both to 8'hFF) -> product=16'h000C.
6. WIDTH=16: 16'h8000*16'h8000 signed -> 32'h40000000, latency 9. 2000 random operand/mode pairs with random out_ready stalls match a behavioural model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded
// partial-product operations and the Booth triplet recoder.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   typedef enum logic [2:0] {OP_ZERO, OP_PM, OP_P2M, OP_NM, OP_N2M} booth_op_e;

   // Triplet is {Q[1], Q[0], Qm}; the overlapping bit makes each digit signed.
   function automatic booth_op_e booth_recode(input logic [2:0] bits);
      booth_op_e op;
      case (bits)
         3'b001, 3'b010: op = OP_PM;
         3'b011:         op = OP_P2M;
         3'b100:         op = OP_N2M;
         3'b101, 3'b110: op = OP_NM;
         default:        op = OP_ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_radix4_mul_if.sv
// Operand-issue and result handshakes of the Booth multiplier.
interface booth_radix4_mul_if #(parameter int WIDTH = 8);

   logic                 in_valid;
   logic                 in_ready;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output in_valid, signed_mode, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product
   );

endinterface

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: selects 0, +-M or +-2M from the
// recoded Booth operation, sign-extended to the accumulator width.
module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int EW = 10
) (
   input  booth_op_e      op,
   input  logic [EW-1:0]  m,
   output logic [EW+1:0]  pp
);

   logic [EW+1:0] m_ext;

   always_comb begin
      m_ext = {{2{m[EW-1]}}, m};
      pp    = '0;
      case (op)
         OP_PM:   pp = m_ext;
         OP_P2M:  pp = m_ext << 1;
         OP_NM:   pp = -m_ext;
         OP_N2M:  pp = -(m_ext << 1);
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier retiring two multiplier bits per cycle,
// with valid/ready handshakes on the operand and product sides.
module booth_radix4_mul
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   booth_radix4_mul_if.slave  bus,
   output logic               busy
);

   localparam int EW = WIDTH + 2;
   localparam int AW = EW + 2;
   localparam int N  = EW / 2;
   localparam int CW = $clog2(N + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_mul: WIDTH must be even and >= 4");
   end

   state_e          state;
   logic [AW-1:0]   a_reg;
   logic [EW-1:0]   q_reg;
   logic            qm;
   logic [EW-1:0]   m_reg;
   logic [CW-1:0]   count;

   booth_op_e       op;
   logic [AW-1:0]   pp;
   logic [AW-1:0]   a_sum;
   logic [AW-1:0]   a_shift;
   logic [EW-1:0]   q_shift;

   booth_pp_gen #(.EW(EW)) u_pp_gen (
      .op (op),
      .m  (m_reg),
      .pp (pp)
   );

   // One Booth step: add the partial product, then shift {A,Q,Qm} right by two.
   always_comb begin
      op      = booth_recode({q_reg[1:0], qm});
      a_sum   = a_reg + pp;
      a_shift = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
      q_shift = {a_sum[1:0], q_reg[EW-1:2]};
   end

   // Signed mode is folded into the operand extension at load time, so the
   // datapath itself never needs to know it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         a_reg         <= '0;
         q_reg         <= '0;
         qm            <= 1'b0;
         m_reg         <= '0;
         count         <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.product   <= '0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  m_reg        <= bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                                  : {2'b00, bus.multiplicand};
                  q_reg        <= bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                                  : {2'b00, bus.multiplier};
                  a_reg        <= '0;
                  qm           <= 1'b0;
                  count        <= '0;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
                  state        <= CALC;
               end
            end
            CALC: begin
               a_reg <= a_shift;
               q_reg <= q_shift;
               qm    <= q_reg[1];
               count <= count + CW'(1);
               if (count == CW'(N - 1)) begin
                  bus.product   <= {a_shift[2*WIDTH-EW-1:0], q_shift};
                  bus.out_valid <= 1'b1;
                  busy          <= 1'b0;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Directed and randomised checks of booth_radix4_mul at WIDTH=8 and WIDTH=16.
module tb_booth_radix4_mul;

   logic clk;
   logic rst;
   logic busy8;
   logic busy16;
   int   checks = 0;
   int   errors = 0;

   booth_radix4_mul_if #(.WIDTH(8))  bus8 ();
   booth_radix4_mul_if #(.WIDTH(16)) bus16 ();

   booth_radix4_mul #(.WIDTH(8)) dut8 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus8),
      .busy (busy8)
   );

   booth_radix4_mul #(.WIDTH(16)) dut16 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus16),
      .busy (busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one 8-bit operation, scramble the operand inputs right after the
   // accept edge, wait (bounded) for out_valid, and consume the product.
   task automatic apply_stimulus8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                                  output int lat, output logic [15:0] prod);
      bus8.signed_mode  = sm;
      bus8.multiplicand = m;
      bus8.multiplier   = q;
      bus8.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid     = 1'b0;
      bus8.multiplicand = 8'hFF;
      bus8.multiplier   = 8'hFF;
      bus8.signed_mode  = ~sm;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      prod = bus8.product;
      @(posedge clk); #1;
   endtask

   task automatic apply_stimulus16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                                   input int stall, output int lat, output logic [31:0] prod);
      bus16.out_ready    = (stall == 0);
      bus16.signed_mode  = sm;
      bus16.multiplicand = m;
      bus16.multiplier   = q;
      bus16.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid     = 1'b0;
      bus16.multiplicand = 16'($urandom);
      bus16.multiplier   = 16'($urandom);
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      repeat (stall) begin
         @(posedge clk); #1;
      end
      prod = bus16.product;
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl8: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                  bus8.in_ready, bus8.out_valid, busy8);
      end
      checks++;
      if (bus8.product !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_product8: got %h expected 0000", bus8.product);
      end
      checks++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || busy16 !== 1'b0 || bus16.product !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset16: got in_ready=%b out_valid=%b busy=%b product=%h expected 1 0 0 0",
                  bus16.in_ready, bus16.out_valid, busy16, bus16.product);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      logic [15:0] prod;
      apply_stimulus8(1'b1, 8'hFD, 8'h07, lat, prod);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d expected 5", lat);
      end
      checks++;
      if (prod !== 16'hFFEB) begin
         errors++;
         $display("[TB] FAIL basic_product: got %h expected ffeb", prod);
      end
   endtask

   task automatic test_corners();
      logic        sm_tab   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0]  op_tab   [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
      logic [15:0] exp_tab  [4] = '{16'h4000, 16'h4000, 16'hFE01, 16'h0001};
      int          lat;
      logic [15:0] prod;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus8(sm_tab[i], op_tab[i], op_tab[i], lat, prod);
         checks++;
         if (prod !== exp_tab[i] || lat !== 5) begin
            errors++;
            $display("[TB] FAIL corner%0d: got product=%h latency=%0d expected %h latency 5",
                     i, prod, lat, exp_tab[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus8.out_ready    = 1'b0;
      bus8.signed_mode  = 1'b1;
      bus8.multiplicand = 8'hFD;
      bus8.multiplier   = 8'h07;
      bus8.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("[TB] FAIL bp_latency: got %0d expected 5", lat);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus8.in_valid     = 1'b1;
            bus8.multiplicand = 8'h02;
            bus8.multiplier   = 8'h02;
         end
         if (i == 4) bus8.in_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (bus8.product !== 16'hFFEB || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got product=%h out_valid=%b in_ready=%b expected ffeb 1 0",
                     i, bus8.product, bus8.out_valid, bus8.in_ready);
         end
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1",
                  bus8.out_valid, bus8.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (busy8 !== 1'b0 || bus8.product !== 16'hFFEB || bus8.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_idle_hold: got busy=%b product=%h in_ready=%b expected 0 ffeb 1",
                  busy8, bus8.product, bus8.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [15:0] prod;
      bus8.signed_mode  = 1'b1;
      bus8.multiplicand = 8'h11;
      bus8.multiplier   = 8'h22;
      bus8.in_valid     = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_busy: got %b expected 1", busy8);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.product !== 16'h0000 || busy8 !== 1'b0 || bus8.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset: got out_valid=%b product=%h busy=%b in_ready=%b expected 0 0000 0 1",
                  bus8.out_valid, bus8.product, busy8, bus8.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      apply_stimulus8(1'b1, 8'h05, 8'h06, lat, prod);
      checks++;
      if (prod !== 16'h001E || lat !== 5) begin
         errors++;
         $display("[TB] FAIL post_reset: got product=%h latency=%0d expected 001e latency 5", prod, lat);
      end
   endtask

   task automatic test_operand_hold();
      int lat;
      logic [15:0] prod;
      apply_stimulus8(1'b0, 8'h03, 8'h04, lat, prod);
      checks++;
      if (prod !== 16'h000C) begin
         errors++;
         $display("[TB] FAIL operand_hold: got %h expected 000c", prod);
      end
   endtask

   task automatic test_width16();
      int          lat;
      logic [31:0] prod;
      logic [31:0] expect_val;
      logic [15:0] m;
      logic [15:0] q;
      logic        sm;
      int          stall;
      apply_stimulus16(1'b1, 16'h8000, 16'h8000, 0, lat, prod);
      checks++;
      if (prod !== 32'h40000000 || lat !== 9) begin
         errors++;
         $display("[TB] FAIL w16_corner: got product=%h latency=%0d expected 40000000 latency 9", prod, lat);
      end
      for (int i = 0; i < 2000; i++) begin
         m     = 16'($urandom);
         q     = 16'($urandom);
         sm    = 1'($urandom);
         stall = $urandom_range(0, 3);
         if (sm) expect_val = {{16{m[15]}}, m} * {{16{q[15]}}, q};
         else    expect_val = {16'h0000, m} * {16'h0000, q};
         apply_stimulus16(sm, m, q, stall, lat, prod);
         checks++;
         if (prod !== expect_val || lat !== 9) begin
            errors++;
            $display("[TB] FAIL w16_rand%0d: got product=%h latency=%0d expected %h latency 9 (m=%h q=%h signed=%b)",
                     i, prod, lat, expect_val, m, q, sm);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus8.in_valid      = 1'b0;
      bus8.signed_mode   = 1'b0;
      bus8.multiplicand  = '0;
      bus8.multiplier    = '0;
      bus8.out_ready     = 1'b1;
      bus16.in_valid     = 1'b0;
      bus16.signed_mode  = 1'b0;
      bus16.multiplicand = '0;
      bus16.multiplier   = '0;
      bus16.out_ready    = 1'b1;
      test_reset();
      test_basic();
      test_corners();
      test_backpressure();
      test_reset_mid();
      test_operand_hold();
      test_width16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
